icache_ctrl: RTL

// Responder end of the fetch-side icache request interface: accepts {req,iscache,offset,index,tag}, returns addr_ok
// on acceptance and data_ok+rdata one or more cycles later. Direct-mapped, 256 sets x 16 B lines, register-array

---
 rtl/icache_ctrl_pkg.sv | 35 +++
 rtl/icache_ctrl_if.sv | 18 +
 rtl/icache_tagv.sv | 40 ++++
 rtl/icache_ctrl.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/icache_ctrl_pkg.sv
// Shared types and constants for the instruction-cache controller.
package cpu_defs;

  localparam int ICACHE_SETS       = 256;
  localparam int ICACHE_LINE_WORDS = 4;
  localparam int ICACHE_TAG_W      = 20;
  localparam int ICACHE_IDX_W      = $clog2(ICACHE_SETS);

  localparam logic [2:0] RD_TYPE_WORD = 3'b010;
  localparam logic [2:0] RD_TYPE_LINE = 3'b100;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MISS,
    REFILL,
    RESP
  } icache_state_t;

  typedef struct packed {
    logic                    iscache;
    logic [3:0]              offset;
    logic [ICACHE_IDX_W-1:0] index;
    logic [ICACHE_TAG_W-1:0] tag;
  } icache_req_t;

  typedef logic [ICACHE_LINE_WORDS-1:0][31:0] line_t;

  // Memory read address: line-aligned for cached fills, word address otherwise.
  function automatic logic [31:0] rd_addr_f(input icache_req_t r);
    if (r.iscache) return {r.tag, r.index, 4'b0000};
    return {r.tag, r.index, r.offset[3:2], 2'b00};
  endfunction

endpackage

// File: rtl/icache_ctrl_if.sv
// Fetch-side request/response bus between the fetch stage and the icache.
interface icache_ctrl_if;
  import cpu_defs::*;

  logic                    req;
  logic                    iscache;
  logic [3:0]              offset;
  logic [ICACHE_IDX_W-1:0] index;
  logic [ICACHE_TAG_W-1:0] tag;
  logic                    addr_ok;
  logic                    data_ok;
  logic [31:0]             rdata;

  modport master (output req, iscache, offset, index, tag,
                  input  addr_ok, data_ok, rdata);
  modport slave  (input  req, iscache, offset, index, tag,
                  output addr_ok, data_ok, rdata);
endinterface

// File: rtl/icache_tagv.sv
// Tag + valid store: async read, sync write, per-set invalidate, valid cleared on reset.
module icache_tagv
  import cpu_defs::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ICACHE_IDX_W-1:0] rd_index_i,
  output logic [ICACHE_TAG_W-1:0] rd_tag_o,
  output logic                    rd_valid_o,
  input  logic                    wr_en_i,
  input  logic [ICACHE_IDX_W-1:0] wr_index_i,
  input  logic [ICACHE_TAG_W-1:0] wr_tag_i,
  input  logic                    inv_en_i,
  input  logic [ICACHE_IDX_W-1:0] inv_index_i
);

  logic [ICACHE_TAG_W-1:0] tag_q [ICACHE_SETS];
  logic [ICACHE_SETS-1:0]  valid_q;

  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_valid_o = valid_q[rd_index_i];

  // Valid bits: cleared on reset or invalidate, set when a cached line is filled.
  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      if (inv_en_i) valid_q[inv_index_i] <= 1'b0;
      if (wr_en_i)  valid_q[wr_index_i]  <= 1'b1;
    end
  end

  // Tag storage written on fill.
  // NOTE: storage arrays carry no reset; the valid bits alone decide whether contents count.
  always_ff @(posedge clk) begin
    if (wr_en_i) tag_q[wr_index_i] <= wr_tag_i;
  end

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller: lookup, single-outstanding refill, invalidate.
module icache_ctrl
  import cpu_defs::*;
(
  input  logic                    clk,
  input  logic                    reset,
  icache_ctrl_if.slave            icache,
  input  logic                    inv_valid_i,
  input  logic [ICACHE_IDX_W-1:0] inv_index_i,
  output logic                    inv_ok_o,
  output logic                    rd_req_o,
  output logic [2:0]              rd_type_o,
  output logic [31:0]             rd_addr_o,
  input  logic                    rd_rdy_i,
  input  logic                    ret_valid_i,
  input  logic                    ret_last_i,
  input  logic [31:0]             ret_data_i
);

  icache_state_t           state_q, state_d;
  icache_req_t             req_buf_q;
  logic [1:0]              cnt_q;
  logic [31:0]             line_buf_q [ICACHE_LINE_WORDS];
  line_t                   data_q     [ICACHE_SETS];
  line_t                   fill_line;
  logic [ICACHE_TAG_W-1:0] tv_tag;
  logic                    tv_valid;
  logic                    hit;
  logic                    addr_ok, data_ok, refill_we, inv_en;
  logic [31:0]             rdata;

  icache_tagv u_tagv (
    .clk         (clk),
    .reset       (reset),
    .rd_index_i  (req_buf_q.index),
    .rd_tag_o    (tv_tag),
    .rd_valid_o  (tv_valid),
    .wr_en_i     (refill_we),
    .wr_index_i  (req_buf_q.index),
    .wr_tag_i    (req_buf_q.tag),
    .inv_en_i    (inv_en),
    .inv_index_i (inv_index_i)
  );

  assign hit       = req_buf_q.iscache & tv_valid & (tv_tag == req_buf_q.tag);
  assign rd_type_o = req_buf_q.iscache ? RD_TYPE_LINE : RD_TYPE_WORD;
  assign rd_addr_o = rd_addr_f(req_buf_q);

  assign icache.addr_ok = addr_ok;
  assign icache.data_ok = data_ok;
  assign icache.rdata   = rdata;

  // Line image written to the data array: buffered beats plus the final beat in flight.
  always_comb begin
    for (int w = 0; w < ICACHE_LINE_WORDS; w++) begin
      fill_line[w] = (2'(w) == cnt_q) ? ret_data_i : line_buf_q[w];
    end
  end

  // Next-state and output decode.
  // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    addr_ok   = 1'b0;
    data_ok   = 1'b0;
    rdata     = '0;
    rd_req_o  = 1'b0;
    inv_ok_o  = 1'b0;
    inv_en    = 1'b0;
    refill_we = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (inv_valid_i) begin
          inv_ok_o = 1'b1;
          inv_en   = 1'b1;
        end else begin
          addr_ok = icache.req;
          if (icache.req) state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          data_ok = 1'b1;
          rdata   = data_q[req_buf_q.index][req_buf_q.offset[3:2]];
          addr_ok = icache.req & ~inv_valid_i;
          state_d = addr_ok ? LOOKUP : IDLE;
        end else begin
          state_d = MISS;
        end
      end
      MISS: begin
        rd_req_o = 1'b1;
        if (rd_rdy_i) state_d = REFILL;
      end
      REFILL: begin
        if (ret_valid_i && ret_last_i) begin
          refill_we = req_buf_q.iscache;
          state_d   = RESP;
        end
      end
      RESP: begin
        data_ok = 1'b1;
        rdata   = req_buf_q.iscache ? line_buf_q[req_buf_q.offset[3:2]] : line_buf_q[0];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Capture the request on every acceptance.
  always_ff @(posedge clk) begin
    if (reset)        req_buf_q <= '0;
    else if (addr_ok) req_buf_q <= '{iscache: icache.iscache, offset: icache.offset,
                                     index: icache.index, tag: icache.tag};
  end

  // Refill beat counter: cleared when the read is accepted, advanced per return beat.
  always_ff @(posedge clk) begin
    if (reset)                                 cnt_q <= '0;
    else if (state_q == MISS && rd_rdy_i)      cnt_q <= '0;
    else if (state_q == REFILL && ret_valid_i) cnt_q <= cnt_q + 2'd1;
  end

  // Collect return beats into the line buffer.
  always_ff @(posedge clk) begin
    if (state_q == REFILL && ret_valid_i) line_buf_q[cnt_q] <= ret_data_i;
  end

  // Data array write on completion of a cached fill.
  always_ff @(posedge clk) begin
    if (refill_we) data_q[req_buf_q.index] <= fill_line;
  end

endmodule
